exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter MUL_BITS_PER_CYCLE, default 1, multiplier bits retired per cycle; legal values 1, 2 and 4; only used with EXEC_MUL_EN.
REQ-003 Port clk, input, 1: the single clock; all state on rising edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port in_valid, input, 1: operation offered.
REQ-006 Port in_ready, output, 1: operation accepted when in_valid && in_ready.
REQ-007 Port alu_sel, input, 1: 0 selects rD2 as operand B, 1 selects sext.
REQ-008 Port alu_op, input, 4: operation code, per REQ-012.
REQ-009 Ports rD1, rD2, sext: input, XLEN each: operand A, register operand B, immediate operand B.
REQ-010 Port flush, input, 1: abort in-flight work and drop the held result.
REQ-011 Ports out_valid (1), out_ready (1, input), alu_c (XLEN), alu_branch (1), out_illegal (1): result handshake, result, branch-taken flag, reserved-opcode flag.

Function
REQ-012 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 MUL (low XLEN bits of the product), 15 reserved.
REQ-013 Operand B SHALL be captured at acceptance as alu_sel ? sext : rD2.
REQ-014 Shift amount SHALL be B[4:0] for XLEN=32 and B[5:0] for XLEN=64.
REQ-015 SLT and SLTU: alu_c = zero-extended 1-bit compare result.
REQ-016 Branch ops: alu_c = 0; alu_branch = condition (BLT and BGE signed).
REQ-017 Non-branch ops: alu_branch = 0.
REQ-018 Add and subtract results SHALL wrap modulo 2^XLEN; no overflow flag.
REQ-019 FSM states: IDLE, MUL, HOLD.
REQ-020 IDLE: accepting a non-MUL op -> HOLD; the result is registered, out_valid=1 the next cycle; latency 1.
REQ-021 IDLE: accepting MUL -> MUL; the down-counter is loaded with XLEN/MUL_BITS_PER_CYCLE.
REQ-022 MUL: one shift-add step per cycle; counter reaching 0 -> HOLD with out_valid=1; latency XLEN/MUL_BITS_PER_CYCLE+1 cycles (33 for defaults).
REQ-023 HOLD: out_valid=1; outputs stable until out_valid && out_ready.
REQ-024 in_ready = (state==IDLE) || (state==HOLD && out_ready); no combinational path from in_valid to in_ready.
REQ-025 HOLD with out_ready and in_valid both high: the new op SHALL be accepted in the same cycle (back-to-back, one result per cycle for non-MUL ops).
REQ-026 Reserved opcode: alu_c=0, alu_branch=0, out_illegal=1, latency 1; otherwise out_illegal=0.
REQ-027 flush SHALL take priority over everything: next state IDLE, out_valid=0, counter cleared, in_ready forced 0 during the flush cycle.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, out_valid=0, alu_c=0, alu_branch=0, out_illegal=0, counter=0, with in_ready=1 from the first clock after release.
REQ-029 Reset asserted mid-MUL SHALL discard the partial product; no output pulse follows release.

Configuration
REQ-030 Macro EXEC_MUL_EN defined: MUL SHALL behave per REQ-021..022.
REQ-031 Macro EXEC_MUL_EN undefined: opcode 14 SHALL be treated as reserved per REQ-026; the MUL state, counter and multiplier datapath SHALL not be synthesised.

Structure
REQ-032 Package exec_pkg SHALL hold the alu_op enum, the FSM state enum and the XLEN-dependent shift-width function.
REQ-033 The iterative multiplier SHALL be one sub-module, exec_mul, with start/done handshake; its instantiation SHALL be guarded by EXEC_MUL_EN.
REQ-034 The combinational ALU SHALL stay inside exec_unit; no further sub-modules.

Verification
REQ-035 ADD, rD1=0xFFFFFFFF, rD2=1, alu_sel=0 -> next cycle out_valid=1, alu_c=0x00000000, alu_branch=0.
REQ-036 SRA, rD1=0x80000000, sext=0x00000024, alu_sel=1 -> alu_c=0xF8000000 (shift amount 4).
REQ-037 BLT, rD1=0xFFFFFFFE, rD2=1 -> alu_branch=1, alu_c=0; then BGE with the same operands -> alu_branch=0.
REQ-038 MUL, 0x00012345 x 0x00000100, EXEC_MUL_EN defined -> in_ready=0 for 32 cycles, then out_valid=1 with alu_c=0x01234500; with the macro undefined -> out_illegal=1 at latency 1.
REQ-039 Ten back-to-back ADDs with out_ready tied high -> ten results on ten consecutive cycles; out_ready held low for 3 cycles -> alu_c stable and in_ready=0 throughout.
REQ-040 flush at cycle 10 of a MUL, and rst_n pulsed low mid-MUL -> out_valid never rises for that op; the next ADD completes in 1 cycle.

Source files
------------

// File: rtl/exec_pkg.sv
// ============================================================================
//  Module      : exec_pkg
//  Description : Shared opcode/state encodings and XLEN-dependent helpers
//                for the exec_unit slice.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exec_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_BEQ  = 4'd10,
        OP_BNE  = 4'd11,
        OP_BLT  = 4'd12,
        OP_BGE  = 4'd13,
        OP_MUL  = 4'd14,
        OP_RSVD = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    function automatic int shamt_width(input int xlen);
        return (xlen == 64) ? 6 : 5;
    endfunction

endpackage

`default_nettype wire

// File: rtl/exec_mul.sv
// ============================================================================
//  Module      : exec_mul
//  Description : Iterative shift-add multiplier, low XLEN bits of the product,
//                BITS_PER_CYCLE multiplier bits retired per step.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_mul #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] product_o
);

    localparam int STEPS = XLEN / BITS_PER_CYCLE;
    localparam int CW    = $clog2(STEPS + 1);

    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] acc_d;
    logic [XLEN-1:0] w_partial;
    logic [CW-1:0]   cnt_q;

    always_comb begin
        w_partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (b_q[i]) begin
                w_partial = w_partial + (a_q << i);
            end
        end
        acc_d = acc_q + w_partial;
    end

    // done marks the step that takes the counter to zero; product is its sum
    assign done_o    = (cnt_q == CW'(1));
    assign product_o = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (abort_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= '0;
            cnt_q <= CW'(STEPS);
        end else if (cnt_q != '0) begin
            a_q   <= a_q << BITS_PER_CYCLE;
            b_q   <= b_q >> BITS_PER_CYCLE;
            acc_q <= acc_d;
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/exec_unit.sv
// ============================================================================
//  Module      : exec_unit
//  Description : Single-issue execution unit: registered ALU/branch results
//                with valid/ready handshake, optional iterative multiplier
//                enabled by the EXEC_MUL_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_unit
    import exec_pkg::*;
#(
    parameter int XLEN               = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            alu_sel,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] rD1,
    input  logic [XLEN-1:0] rD2,
    input  logic [XLEN-1:0] sext,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_c,
    output logic            alu_branch,
    output logic            out_illegal
);

    localparam int SHW = shamt_width(XLEN);
`ifdef EXEC_MUL_EN
    localparam bit MUL_BUILD = 1'b1;
`else
    localparam bit MUL_BUILD = 1'b0;
`endif
    localparam bit MUL_CFG_OK  = (MUL_BITS_PER_CYCLE == 1) || (MUL_BITS_PER_CYCLE == 2) ||
                                 (MUL_BITS_PER_CYCLE == 4);
    localparam bit MUL_ENABLED = MUL_BUILD && MUL_CFG_OK;

    state_e          state_q, state_d;
    logic [XLEN-1:0] alu_c_q, alu_c_d;
    logic            br_q, br_d;
    logic            ill_q, ill_d;

    logic [XLEN-1:0] w_b;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_res;
    logic            w_br;
    logic            w_ill;
    logic            w_accept;

    assign w_b     = alu_sel ? sext : rD2;
    assign w_shamt = w_b[SHW-1:0];

    always_comb begin
        w_res = '0;
        w_br  = 1'b0;
        w_ill = 1'b0;
        case (alu_op)
            OP_ADD:  w_res = rD1 + w_b;
            OP_SUB:  w_res = rD1 - w_b;
            OP_AND:  w_res = rD1 & w_b;
            OP_OR:   w_res = rD1 | w_b;
            OP_XOR:  w_res = rD1 ^ w_b;
            OP_SLL:  w_res = rD1 << w_shamt;
            OP_SRL:  w_res = rD1 >> w_shamt;
            OP_SRA:  w_res = $signed(rD1) >>> w_shamt;
            OP_SLT:  w_res = {{(XLEN-1){1'b0}}, $signed(rD1) < $signed(w_b)};
            OP_SLTU: w_res = {{(XLEN-1){1'b0}}, rD1 < w_b};
            OP_BEQ:  w_br  = (rD1 == w_b);
            OP_BNE:  w_br  = (rD1 != w_b);
            OP_BLT:  w_br  = ($signed(rD1) < $signed(w_b));
            OP_BGE:  w_br  = ($signed(rD1) >= $signed(w_b));
            OP_MUL:  w_ill = !MUL_ENABLED;
            default: w_ill = 1'b1;
        endcase
    end

    // in_ready depends only on state, out_ready and flush, never on in_valid
    assign in_ready  = !flush && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (state_q == ST_HOLD) && !flush;

`ifdef EXEC_MUL_EN
    logic            w_is_mul;
    logic            w_mul_start;
    logic            w_mul_done;
    logic [XLEN-1:0] w_mul_prod;

    assign w_is_mul = (alu_op == OP_MUL) && MUL_ENABLED;

    exec_mul #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (MUL_BITS_PER_CYCLE)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (w_mul_start),
        .abort_i   (flush),
        .a_i       (rD1),
        .b_i       (w_b),
        .done_o    (w_mul_done),
        .product_o (w_mul_prod)
    );
`endif

    always_comb begin
        state_d = state_q;
        alu_c_d = alu_c_q;
        br_d    = br_q;
        ill_d   = ill_q;
`ifdef EXEC_MUL_EN
        w_mul_start = 1'b0;
`endif
        if (flush) begin
            state_d = ST_IDLE;
        end else if (w_accept) begin
`ifdef EXEC_MUL_EN
            if (w_is_mul) begin
                state_d     = ST_MUL;
                w_mul_start = 1'b1;
            end else
`endif
            begin
                state_d = ST_HOLD;
                alu_c_d = w_res;
                br_d    = w_br;
                ill_d   = w_ill;
            end
        end else if ((state_q == ST_HOLD) && out_ready) begin
            state_d = ST_IDLE;
        end
`ifdef EXEC_MUL_EN
        else if ((state_q == ST_MUL) && w_mul_done) begin
            state_d = ST_HOLD;
            alu_c_d = w_mul_prod;
            br_d    = 1'b0;
            ill_d   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            alu_c_q <= '0;
            br_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            alu_c_q <= alu_c_d;
            br_q    <= br_d;
            ill_q   <= ill_d;
        end
    end

    assign alu_c       = alu_c_q;
    assign alu_branch  = br_q;
    assign out_illegal = ill_q;

endmodule

`default_nettype wire

// File: tb/tb_exec_unit.sv
// ============================================================================
//  Module      : tb_exec_unit
//  Description : Self-checking bench for exec_unit (XLEN=32); follows the
//                EXEC_MUL_EN macro of the build for MUL expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exec_unit;

`ifdef EXEC_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        alu_sel = 1'b0;
    logic [3:0]  alu_op = 4'd0;
    logic [31:0] rD1 = '0, rD2 = '0, sext = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] alu_c;
    logic        alu_branch;
    logic        out_illegal;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    exec_unit #(.XLEN(32), .MUL_BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_sel(alu_sel), .alu_op(alu_op), .rD1(rD1), .rD2(rD2), .sext(sext),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_c(alu_c), .alu_branch(alu_branch), .out_illegal(out_illegal)
    );

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input bit ok, input string name, input string detail);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    // Reference behaviour: {illegal, branch, result}
    function automatic logic [33:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [31:0] c;
        logic br, ill;
        sa = a; sb = b; c = 0; br = 0; ill = 0;
        case (op)
            4'd0:  c = a + b;
            4'd1:  c = a - b;
            4'd2:  c = a & b;
            4'd3:  c = a | b;
            4'd4:  c = a ^ b;
            4'd5:  c = a << (b % 32);
            4'd6:  c = a >> (b % 32);
            4'd7:  c = sa >>> (b % 32);
            4'd8:  c = (sa < sb) ? 1 : 0;
            4'd9:  c = (a < b) ? 1 : 0;
            4'd10: br = (a == b);
            4'd11: br = (a != b);
            4'd12: br = (sa < sb);
            4'd13: br = !(sa < sb);
            4'd14: if (MUL_ON) c = 32'(64'(a) * 64'(b)); else ill = 1;
            default: ill = 1;
        endcase
        return {ill, br, c};
    endfunction

    // Offer one op at a negedge from idle; report result, latency and in_ready-low cycles
    task automatic run_op(input logic [3:0] op, input logic sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] s,
                          output logic [31:0] c, output logic br, output logic ill,
                          output int lat, output int ir_low);
        alu_op = op; alu_sel = sel; rD1 = a; rD2 = b; sext = s;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1; ir_low = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) ir_low++;
            @(negedge clk);
            lat++;
        end
        c = alu_c; br = alu_branch; ill = out_illegal;
        @(negedge clk);
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        sel;
        logic [31:0] a, b, s, c;
        logic        br, ill;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [31:0] c, expc;
        logic br, ill;
        int lat, irl, seen;
        logic [33:0] m;
        logic [31:0] exp_q[$];
        logic [31:0] held;

        vecs[0]  = '{"ADD_wrap", 4'd0, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 1};
        vecs[1]  = '{"SUB_wrap", 4'd1, 1'b0, 32'h0, 32'h1, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 1};
        vecs[2]  = '{"AND", 4'd2, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'hF000F000, 1'b0, 1'b0, 1};
        vecs[3]  = '{"OR_sext", 4'd3, 1'b1, 32'hF0F0F0F0, 32'h0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1};
        vecs[4]  = '{"XOR", 4'd4, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0FF00FF0, 1'b0, 1'b0, 1};
        vecs[5]  = '{"SLL_mask", 4'd5, 1'b1, 32'h1, 32'h7, 32'h21, 32'h2, 1'b0, 1'b0, 1};
        vecs[6]  = '{"SRL_31", 4'd6, 1'b0, 32'h80000000, 32'h1F, 32'h0, 32'h1, 1'b0, 1'b0, 1};
        vecs[7]  = '{"SRA_sext", 4'd7, 1'b1, 32'h80000000, 32'h3, 32'h24, 32'hF8000000, 1'b0, 1'b0, 1};
        vecs[8]  = '{"SLT", 4'd8, 1'b0, 32'hFFFFFFFE, 32'h1, 32'h0, 32'h1, 1'b0, 1'b0, 1};
        vecs[9]  = '{"SLTU", 4'd9, 1'b0, 32'hFFFFFFFE, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 1};
        vecs[10] = '{"BEQ", 4'd10, 1'b0, 32'h5, 32'h5, 32'h0, 32'h0, 1'b1, 1'b0, 1};
        vecs[11] = '{"BNE", 4'd11, 1'b0, 32'h5, 32'h5, 32'h0, 32'h0, 1'b0, 1'b0, 1};
        vecs[12] = '{"BLT", 4'd12, 1'b0, 32'hFFFFFFFE, 32'h1, 32'h0, 32'h0, 1'b1, 1'b0, 1};
        vecs[13] = '{"BGE", 4'd13, 1'b0, 32'hFFFFFFFE, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 1};
        vecs[14] = '{"RSVD", 4'd15, 1'b0, 32'h1234, 32'h5678, 32'h0, 32'h0, 1'b0, 1'b1, 1};
        if (MUL_ON)
            vecs[15] = '{"MUL", 4'd14, 1'b0, 32'h00012345, 32'h100, 32'h0, 32'h01234500, 1'b0, 1'b0, 33};
        else
            vecs[15] = '{"MUL_off", 4'd14, 1'b0, 32'h00012345, 32'h100, 32'h0, 32'h0, 1'b0, 1'b1, 1};

        // Reset state
        repeat (3) @(negedge clk);
        chk(!out_valid && alu_c == 0 && !alu_branch && !out_illegal, "reset_outputs",
            $sformatf("valid=%0b c=%h br=%0b ill=%0b, want 0/0/0/0", out_valid, alu_c, alu_branch, out_illegal));
        rst_n = 1'b1;
        @(negedge clk);
        chk(in_ready === 1'b1, "reset_in_ready", $sformatf("in_ready=%0b want 1", in_ready));

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].s, c, br, ill, lat, irl);
            chk(c == vecs[i].c && br == vecs[i].br && ill == vecs[i].ill && lat == vecs[i].lat,
                vecs[i].name, $sformatf("c=%h br=%0b ill=%0b lat=%0d, want c=%h br=%0b ill=%0b lat=%0d",
                c, br, ill, lat, vecs[i].c, vecs[i].br, vecs[i].ill, vecs[i].lat));
            if (vecs[i].op == 4'd14 && MUL_ON)
                chk(irl == 32, "MUL_in_ready_low", $sformatf("in_ready low %0d cycles, want 32", irl));
        end

        // Back-to-back ADDs
        for (int k = 0; k < 11; k++) begin
            if (k > 0) begin
                expc = exp_q.pop_front();
                chk(out_valid && alu_c == expc, $sformatf("b2b_%0d", k - 1),
                    $sformatf("valid=%0b c=%h, want 1/%h", out_valid, alu_c, expc));
            end
            if (k < 10) begin
                alu_op = 4'd0; alu_sel = 1'b0; rD1 = $urandom; rD2 = $urandom;
                exp_q.push_back(rD1 + rD2);
                in_valid = 1'b1; out_ready = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end

        // Output stall for three cycles with a second op waiting
        alu_op = 4'd1; rD1 = 32'd100; rD2 = 32'd58; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        held = alu_c;
        alu_op = 4'd4; rD1 = 32'hAAAA5555; rD2 = 32'h0F0F0F0F;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            if (!(out_valid && alu_c == 32'd42 && !in_ready)) seen++;
            if (k < 2) @(negedge clk);
        end
        chk(seen == 0 && held == 32'd42, "stall_stable",
            $sformatf("%0d bad stall cycles, first c=%h, want 0 and 2a", seen, held));
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk(out_valid && alu_c == 32'hA5A55A5A, "stall_next",
            $sformatf("valid=%0b c=%h, want 1/a5a55a5a", out_valid, alu_c));
        @(negedge clk);

        // Flush mid-operation
        alu_op = 4'd14; rD1 = 32'h3; rD2 = 32'h5; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        chk(!in_ready && !out_valid, "flush_cycle",
            $sformatf("in_ready=%0b out_valid=%0b, want 0/0", in_ready, out_valid));
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b1;
        seen = 0;
        repeat (40) begin @(negedge clk); if (out_valid) seen++; end
        chk(seen == 0, "flush_no_result", $sformatf("out_valid seen %0d cycles, want 0", seen));
        run_op(4'd0, 1'b0, 32'd3, 32'd4, 32'd0, c, br, ill, lat, irl);
        chk(c == 32'd7 && lat == 1, "flush_then_add", $sformatf("c=%h lat=%0d, want 7/1", c, lat));

        // Reset pulse mid-operation
        alu_op = 4'd14; rD1 = 32'h9; rD2 = 32'h9; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk(!out_valid && alu_c == 0 && !alu_branch && !out_illegal, "async_reset",
            $sformatf("valid=%0b c=%h br=%0b ill=%0b, want all 0", out_valid, alu_c, alu_branch, out_illegal));
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk(in_ready === 1'b1, "reset_release_ready", $sformatf("in_ready=%0b want 1", in_ready));
        seen = 0;
        repeat (40) begin @(negedge clk); if (out_valid) seen++; end
        chk(seen == 0, "reset_no_result", $sformatf("out_valid seen %0d cycles, want 0", seen));
        run_op(4'd0, 1'b1, 32'd10, 32'd999, 32'd20, c, br, ill, lat, irl);
        chk(c == 32'd30 && lat == 1, "reset_then_add", $sformatf("c=%h lat=%0d, want 1e/1", c, lat));

        // Randomised ops against the reference model
        for (int k = 0; k < 150; k++) begin
            logic [3:0]  op;
            logic        sel;
            logic [31:0] a, b, s, bb;
            int          elat;
            op = 4'($urandom_range(0, 15));
            sel = 1'($urandom);
            a = $urandom; b = $urandom; s = $urandom;
            if ($urandom_range(0, 3) == 0) begin b = a; s = a; end
            if ($urandom_range(0, 3) == 0) a = {{16{a[15]}}, a[15:0]};
            bb = sel ? s : b;
            m = model(op, a, bb);
            elat = (op == 4'd14 && MUL_ON) ? 33 : 1;
            run_op(op, sel, a, b, s, c, br, ill, lat, irl);
            chk(c == m[31:0] && br == m[32] && ill == m[33] && lat == elat, $sformatf("rand_%0d_op%0d", k, op),
                $sformatf("c=%h br=%0b ill=%0b lat=%0d, want c=%h br=%0b ill=%0b lat=%0d",
                c, br, ill, lat, m[31:0], m[32], m[33], elat));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
